// File: rtl/noc_rr_arbiter.sv
// Round-robin arbiter that merges CPU_NB valid/ready request streams into one
// registered NOC output stage. Each beat is tagged with its source index. A
// requester may keep the grant for up to MAX_BURST consecutive beats.
module noc_rr_arbiter #(
  parameter int unsigned CPU_NB    = 4,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned IDX_W     = $clog2(CPU_NB)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CPU_NB-1:0]             in_vld,
  output logic [CPU_NB-1:0]             in_rdy,
  input  logic [CPU_NB-1:0][DATA_W-1:0] in_data,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [DATA_W-1:0]             out_data,
  output logic [IDX_W-1:0]              out_src,
  output logic                          busy
);

  localparam int unsigned      CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CPU_NB - 1);

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] cand;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_nxt;
  logic             win_vld;
  logic             lock;
  logic             load_en;

  assign load_en = !out_vld || out_rdy;

  // The previous winner keeps the grant while it is still requesting and its
  // burst has started but not reached the limit.
  assign lock = in_vld[last_grant] && (burst_cnt != '0) && (burst_cnt < BURST_LIM);

  // Winner search: locked requester, otherwise first valid index after
  // last_grant with wrap; last_grant is examined last.
  always_comb begin
    winner  = last_grant;
    win_vld = 1'b0;
    cand    = '0;
    if (lock) begin
      win_vld = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= CPU_NB; k++) begin
        cand = IDX_W'((32'(last_grant) + k) % CPU_NB);
        if (!win_vld && in_vld[cand]) begin
          winner  = cand;
          win_vld = 1'b1;
        end
      end
    end
  end

  // Burst counter advance for the current winner.
  always_comb begin
    burst_nxt = CNT_W'(1);
    if (winner == last_grant && burst_cnt < BURST_LIM) begin
      burst_nxt = burst_cnt + 1'b1;
    end
  end

  // Accept strobe; gated by rst_n because during reset the empty output stage
  // would otherwise advertise a load slot.
  always_comb begin
    in_rdy = '0;
    if (rst_n && load_en && win_vld) begin
      in_rdy = CPU_NB'(1) << winner;
    end
  end

  assign busy = out_vld || (|in_vld);

  // Output stage, grant history and burst count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld    <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      last_grant <= LAST_IDX;
      burst_cnt  <= '0;
    end else if (load_en) begin
      if (win_vld) begin
        out_vld    <= 1'b1;
        out_data   <= in_data[winner];
        out_src    <= winner;
        last_grant <= winner;
        burst_cnt  <= burst_nxt;
      end else begin
        out_vld    <= 1'b0;
        burst_cnt  <= '0;
      end
    end
  end

endmodule
